seq_pattern_detect: RTL and testbench

- Parametrised, runtime-programmable serial pattern detector; successor to the fixed 4-ones Moore detector.
- Watches a 1-bit serial stream for a loaded pattern of 1..PAT_W bits, in overlapping or non-overlapping mode.
- Raises a registered Moore-style match flag and keeps a saturating match counter.
- Sits on the serial input path ahead of framing/control logic.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/sat_counter.sv | 22 ++
 rtl/seq_pattern_detect.sv | 125 ++++++++++++
 tb/tb_seq_pattern_detect.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam logic OVERLAP_ON  = 1'b1;
  localparam logic OVERLAP_OFF = 1'b0;

  // A length is usable only if it selects at least one and at most max_len bits.
  function automatic logic len_legal(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= W'(inc);
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_detect.sv
// Runtime-programmable serial pattern detector with overlap control,
// registered match pulse and saturating match counter.
//
//   state | meaning
//   IDLE  | no legal configuration loaded; samples ignored
//   FILL  | collecting samples until history holds cfg_len bits
//   ARMED | history full; every accepted sample can match
module seq_pattern_detect
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err,
  output logic             armed
);

  state_t state, state_next;

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill;
  logic [LEN_W:0]   fill_p1;
  logic [PAT_W-1:0] mask;
  logic             accept;
  logic             full_next;
  logic             match;
  logic             load_legal;

  assign accept     = x_valid && !cfg_load && (state != IDLE);
  assign hist_next  = {hist, x};
  assign fill_p1    = {1'b0, fill} + (LEN_W + 1)'(1);
  assign full_next  = (fill_p1 >= {1'b0, len_q});
  assign load_legal = len_legal(int'(cfg_len), PAT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (cfg_load) begin
      state_next = load_legal ? FILL : IDLE;
    end else begin
      case (state)
        IDLE:  state_next = IDLE;
        FILL: begin
          if (accept) begin
            if (match && (ovl_q == OVERLAP_OFF)) state_next = FILL;
            else if (full_next)                  state_next = ARMED;
          end
        end
        ARMED: begin
          if (match && (ovl_q == OVERLAP_OFF)) state_next = FILL;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Only the low len_q bits of history and pattern take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    match = accept && full_next && ((hist_next & mask) == (pat_q & mask));
    armed = (state == ARMED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= OVERLAP_OFF;
      hist    <= '0;
      fill    <= '0;
      y       <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      y <= match;
      if (cfg_load) begin
        pat_q   <= cfg_pattern;
        len_q   <= cfg_len;
        ovl_q   <= cfg_overlap;
        hist    <= '0;
        fill    <= '0;
        cfg_err <= !load_legal;
      end else if (accept) begin
        hist <= hist_next[PAT_W-2:0];
        if (match && (ovl_q == OVERLAP_OFF)) fill <= '0;
        else if (full_next)                  fill <= len_q;
        else                                 fill <= fill_p1[LEN_W-1:0];
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match),
    .clr   (cnt_clr || cfg_load),
    .q     (match_cnt)
  );

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Directed bench for seq_pattern_detect: expected y pulses are queued as each
// sample is driven and checked one edge later; counters/flags checked inline.
module tb_seq_pattern_detect;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk;
  logic             rst_n;
  logic             x;
  logic             x_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;
  logic             armed;

  int   tests = 0;
  int   fails = 0;
  logic exp_q[$];

  seq_pattern_detect #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .y           (y),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err),
    .armed       (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pop the expected y queued for the edge just taken and compare.
  task automatic check_y(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(y), 32'(e));
    end
  endtask

  task automatic send(input logic xb, input logic vb, input logic ey, input string tag);
    x       = xb;
    x_valid = vb;
    exp_q.push_back(ey);
    @(posedge clk);
    #1;
    check_y(tag);
  endtask

  // Bits are sent from index n-1 down to 0; ey[i] is the y expected after bits[i].
  task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] ey,
                        input string tag);
    for (int i = n - 1; i >= 0; i--) send(bits[i], 1'b1, ey[i], tag);
    x_valid = 1'b0;
  endtask

  // Load drives a valid 1 sample in the same cycle; it must be discarded.
  task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cnt_clr     = 1'b1;
    x           = 1'b1;
    x_valid     = 1'b1;
    exp_q.push_back(1'b0);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    x_valid  = 1'b0;
    check_y("load_y");
    chk("load_cnt", 32'(match_cnt), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    #12;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    send(1'b1, 1'b1, 1'b0, "idle_ignore");
    send(1'b1, 1'b1, 1'b0, "idle_ignore");

    // 1111 overlapping: run of ones keeps y high
    load(8'b0000_1111, 4'd4, 1'b1);
    stream(16'b0111111, 7, 16'b0000111, "ovl_ones");
    chk("ovl_ones_cnt", 32'(match_cnt), 32'd3);
    chk("ovl_ones_armed", 32'(armed), 32'd1);
    send(1'b1, 1'b0, 1'b0, "valid_low");

    // 1111 non-overlapping: pulses after 4 and 8
    load(8'b0000_1111, 4'd4, 1'b0);
    stream(16'b11111111, 8, 16'b00010001, "novl_ones");
    chk("novl_ones_cnt", 32'(match_cnt), 32'd2);
    chk("novl_armed", 32'(armed), 32'd0);

    // 10110, upper pattern bits junk to exercise masking
    load(8'b1111_0110, 4'd5, 1'b1);
    stream(16'b1011010110, 10, 16'b0000100001, "p10110_ovl");
    chk("p10110_ovl_cnt", 32'(match_cnt), 32'd2);
    load(8'b1111_0110, 4'd5, 1'b0);
    stream(16'b1011010110, 10, 16'b0000100001, "p10110_novl");
    load(8'b0001_0110, 4'd5, 1'b1);
    stream(16'b10110110, 8, 16'b00001001, "p10110_shared");
    load(8'b0001_0110, 4'd5, 1'b0);
    stream(16'b10110110, 8, 16'b00001000, "p10110_noshare");

    // valid gaps inside the pattern
    load(8'b0001_0110, 4'd5, 1'b1);
    send(1'b1, 1'b1, 1'b0, "gap");
    send(1'b0, 1'b0, 1'b0, "gap");
    send(1'b0, 1'b1, 1'b0, "gap");
    send(1'b1, 1'b1, 1'b0, "gap");
    send(1'b0, 1'b0, 1'b0, "gap");
    send(1'b1, 1'b1, 1'b0, "gap");
    send(1'b0, 1'b1, 1'b1, "gap_match");
    chk("gap_cnt", 32'(match_cnt), 32'd1);

    // illegal lengths
    load(8'b0000_0000, 4'd0, 1'b1);
    chk("len0_err", 32'(cfg_err), 32'd1);
    chk("len0_armed", 32'(armed), 32'd0);
    stream(16'b0000, 4, 16'b0000, "len0_nomatch");
    chk("len0_cnt", 32'(match_cnt), 32'd0);
    load(8'b1111_1111, 4'd9, 1'b1);
    chk("len9_err", 32'(cfg_err), 32'd1);
    stream(16'b1111, 4, 16'b0000, "len9_nomatch");

    // len 1, saturation and clear-with-match
    load(8'b0000_0001, 4'd1, 1'b1);
    chk("legal_err_clr", 32'(cfg_err), 32'd0);
    stream(16'b11111, 5, 16'b11111, "len1_ovl");
    chk("sat_cnt", 32'(match_cnt), 32'd3);
    cnt_clr = 1'b1;
    send(1'b1, 1'b1, 1'b1, "clr_match");
    cnt_clr = 1'b0;
    chk("clr_match_cnt", 32'(match_cnt), 32'd1);
    cnt_clr = 1'b1;
    send(1'b1, 1'b0, 1'b0, "clr_only");
    cnt_clr = 1'b0;
    chk("clr_only_cnt", 32'(match_cnt), 32'd0);
    load(8'b0000_0000, 4'd1, 1'b0);
    stream(16'b010, 3, 16'b101, "len1_novl");
    chk("len1_novl_armed", 32'(armed), 32'd0);
    chk("len1_novl_cnt", 32'(match_cnt), 32'd2);

    // asynchronous reset mid-stream
    load(8'b0000_1111, 4'd4, 1'b1);
    stream(16'b1111, 4, 16'b0001, "pre_reset");
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_y", 32'(y), 32'd0);
    chk("async_cnt", 32'(match_cnt), 32'd0);
    chk("async_armed", 32'(armed), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stream(16'b11111, 5, 16'b00000, "post_reset_idle");
    chk("post_reset_cnt", 32'(match_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
